// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one WIDTH-bit ALU between two requesters:
//   requester 0 = pipeline EX stage, requester 1 = sort compare-and-swap engine.
// A winner is picked in IDLE, its operands are latched, the operation runs in
// a dedicated EXEC cycle, and the result plus branch flags are held on a single
// tagged response channel until the consumer takes it.
//
// Build option:
//   ALU_SHARE_FIXED_PRIO_EN  - when defined, requester 0 always wins a tie and
//                              no round-robin pointer exists. Default build
//                              (undefined) is round-robin.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid[1:0]          per-requester operation pending
//   req_ready[1:0]          one-hot acceptance pulse (combinational, IDLE only)
//   a0/b0/aluop0/func3_0    requester 0 operands, opcode, branch func3
//   a1/b1/aluop1/func3_1    requester 1 operands, opcode, branch func3
//   rsp_valid / rsp_ready   response handshake (consumer may back-pressure)
//   rsp_id                  owner of the response
//   rsp_result              ALU result
//   rsp_zero                result==0 with func3==000 (BEQ-style)
//   rsp_lt                  result MSB set with func3==100 (BLT-style)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [3:0]       aluop0,
  input  logic [2:0]       func3_0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [3:0]       aluop1,
  input  logic [2:0]       func3_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_lt
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  logic any_valid;
  logic grant_id;
  logic accept;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [3:0]              aluop_p0;
  logic [2:0]              func3_p0;
  logic                    id_p0;
  logic signed [WIDTH-1:0] result_p1;

  function automatic logic signed [WIDTH-1:0] alu_exec(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic [3:0]              op
  );
    case (op)
      4'b0000: alu_exec = a & b;
      4'b0001: alu_exec = a | b;
      4'b0010: alu_exec = a + b;
      4'b0110: alu_exec = a - b;
      4'b1100: alu_exec = ~(a | b);
      4'b1000: alu_exec = a << b[SHW-1:0];
      default: alu_exec = '0;
    endcase
  endfunction

  function automatic logic flag_zero(input logic signed [WIDTH-1:0] res,
                                     input logic [2:0] f3);
    flag_zero = (res == '0) && (f3 == 3'b000);
  endfunction

  // Sign bit of the wrapped difference, not a true signed compare.
  function automatic logic flag_lt(input logic signed [WIDTH-1:0] res,
                                   input logic [2:0] f3);
    flag_lt = res[WIDTH-1] && (f3 == 3'b100);
  endfunction

  assign any_valid = |req_valid;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  always_comb begin
    grant_id = ~req_valid[0];
  end
`else
  // Pointer names the requester that wins a tie; it moves to the requester
  // that did not own the last completed response.
  logic ptr;

  always_comb begin
    grant_id = req_valid[ptr] ? ptr : ~ptr;
  end
`endif

  always_comb begin
    req_ready = 2'b00;
    if (!reset && (state == IDLE) && any_valid) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // ---- stage p0: operand capture at acceptance ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0     <= grant_id ? a1 : a0;
      b_p0     <= grant_id ? b1 : b0;
      aluop_p0 <= grant_id ? aluop1 : aluop0;
      func3_p0 <= grant_id ? func3_1 : func3_0;
      id_p0    <= grant_id;
    end
  end

  // ---- stage p1: execute on latched operands ----
  always_comb begin
    result_p1 = alu_exec(a_p0, b_p0, aluop_p0);
  end

  // ---- control FSM and registered response ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_lt     <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= result_p1;
          rsp_zero   <= flag_zero(result_p1, func3_p0);
          rsp_lt     <= flag_lt(result_p1, func3_p0);
          rsp_id     <= id_p0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            ptr       <= ~rsp_id;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 64-bit ALU between two requesters: requester 0 is the pipeline EX stage and requester 1 is the sort compare-and-swap engine.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Operands are registered and the operation is executed in a dedicated cycle.
- The result and branch flags are returned on a single tagged response channel that the consumer can back-pressure.

Parameters:
- WIDTH, 64, operand/result width; shift amount uses b[5:0] for 64 (log2(WIDTH) bits generally)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i has an operation pending
- req_ready  out  2  bit i: requester i's operation accepted this cycle
- a0  in  WIDTH  requester 0 operand A
- b0  in  WIDTH  requester 0 operand B
- aluop0  in  4  requester 0 ALU opcode
- func3_0  in  3  requester 0 branch func3
- a1  in  WIDTH  requester 1 operand A
- b1  in  WIDTH  requester 1 operand B
- aluop1  in  4  requester 1 ALU opcode
- func3_1  in  3  requester 1 branch func3
- rsp_valid  out  1  response holds a completed result
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  WIDTH  ALU result
- rsp_zero  out  1  result==0 and func3==3'b000
- rsp_lt  out  1  result[WIDTH-1]==1 and func3==3'b100

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset:
  - state=IDLE, priority pointer=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_lt=0.
  - req_ready=0 (combinational, so 0 while reset is high).
  - Reset mid-operation discards the in-flight operation; no response is issued.
- IDLE:
  - req_ready is combinational and one-hot; it goes to the winner only.
  - Winner = requester at the pointer if it is valid, else the other requester if it is valid.
  - If any request is valid, latch the winner's a, b, aluop, func3 and id, then go to EXEC.
  - If no request is valid, stay in IDLE with req_ready=0.
- EXEC:
  - req_ready=0.
  - Compute on the latched operands:
    - 0000 AND
    - 0001 OR
    - 0010 ADD (mod 2^WIDTH)
    - 0110 SUB (mod 2^WIDTH)
    - 1100 NOR
    - 1000 SLL by b[5:0]
    - any other opcode: result 0
  - Register rsp_result, rsp_zero, rsp_lt and rsp_id, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid, set pointer = ~rsp_id, go to IDLE.
  - rsp_result, rsp_id and the flags keep their last values after rsp_valid drops.
- Latency and throughput:
  - Acceptance edge to rsp_valid: 1 cycle.
  - Best-case throughput: 1 operation per 3 cycles.
  - No new request is accepted while in EXEC or RESP.
- Arbitration:
  - Both requesters valid in IDLE: the pointer selects the winner. After reset, requester 0 wins first.
  - Under continuous contention, grants alternate 0,1,0,1.
- req_valid deasserted before grant: no effect, no grant. A requester must hold its operands stable until its req_ready pulse.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins when both are valid.
  - The pointer register is not implemented.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
1. Reset, then req_valid=01 with a0=5, b0=3, aluop0=0010, func3_0=000 -> req_ready=01 for one cycle. rsp_valid rises 1 cycle later with rsp_id=0, rsp_result=8, rsp_zero=0, rsp_lt=0.
2. req_valid=10 with a1=7, b1=7, aluop1=0110, func3_1=000 -> rsp_id=1, rsp_result=0, rsp_zero=1.
3. a0=3, b0=9, aluop0=0110, func3_0=100 -> rsp_result=0xFFFF_FFFF_FFFF_FFFA, rsp_lt=1. Same operands with func3_0=000 -> rsp_lt=0.
4. req_valid=11 held through four transactions with rsp_ready=1 -> grant order 0,1,0,1. With ALU_SHARE_FIXED_PRIO_EN defined -> grant order 0,0,0,0.
5. rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_result stable, req_ready=00. Then rsp_ready=1 -> IDLE next cycle, the next grant is issued.
6. Assert reset during EXEC -> next cycle state=IDLE and rsp_valid=0, with no response for the dropped operation. Then a1=1, b1=64, aluop1=1000 -> rsp_result=1 (shift by 0). aluop=1111 -> rsp_result=0.
